// File: rtl/sfx_mixer.sv
// -----------------------------------------------------------------------------
// sfx_mixer
//
// Purpose:
//   Mixes three sound-effect square waves and one background-music square wave
//   onto a single PWM-gated speaker pin. Each source stays "active" for ACT_WIN
//   clocks after its last edge. A small FSM picks the highest-priority active
//   source (squash > home > jump > music). The selected source's registered
//   level is then gated by a free-running PWM carrier against the volume input.
//
// Configuration:
//   SFX_MUSIC_EN - when defined, the music channel and the MUSIC state are
//                  present. When undefined (the default build), music_snd is
//                  ignored, EFFECT falls back to IDLE, and IDLE only enters
//                  EFFECT.
//
// Ports:
//   clk         in   system clock (25.175 MHz)
//   reset_n     in   synchronous active-low reset
//   squash_snd  in   squash effect tone
//   home_snd    in   frog-home effect tone
//   jump_snd    in   jump effect tone
//   music_snd   in   background music tone
//   volume      in   PWM duty in 1/8 steps (0 = silent)
//   mute        in   forces audio_out low
//   audio_out   out  registered PWM-gated audio
//   sel         out  selected source: 0 none/music, 1 jump, 2 home, 3 squash
//   sfx_busy    out  high while an effect (not music) is selected
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | nothing active, output silent
//   MUSIC   | only music active, music drives the output
//   EFFECT  | an effect owns the output (sel = 1..3)
// -----------------------------------------------------------------------------
module sfx_mixer #(
    parameter logic [15:0] ACT_WIN  = 16'd40000,
    parameter int          PWM_BITS = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                squash_snd,
    input  logic                home_snd,
    input  logic                jump_snd,
    input  logic                music_snd,
    input  logic [PWM_BITS-1:0] volume,
    input  logic                mute,
    output logic                audio_out,
    output logic [1:0]          sel,
    output logic                sfx_busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
`ifdef SFX_MUSIC_EN
    localparam logic [1:0] ST_MUSIC  = 2'd1;
`endif
    localparam logic [1:0] ST_EFFECT = 2'd2;

    // Bit index of each source equals its sel code: 0 music, 1 jump, 2 home, 3 squash.
    logic [3:0]          w_src;
    logic [3:0]          w_edge;
    logic [3:0]          w_act;
    logic [1:0]          w_best;
    logic [1:0]          w_state_nx;
    logic [1:0]          w_sel_nx;
    logic                w_level;

    logic [3:0]          r_src_q;
    logic [15:0]         r_cnt [4];
    logic [1:0]          r_state;
    logic [1:0]          r_sel;
    logic                r_busy;
    logic                r_audio;
    logic [PWM_BITS-1:0] r_carrier;

`ifdef SFX_MUSIC_EN
    assign w_src = {squash_snd, home_snd, jump_snd, music_snd};
`else
    // Music channel tied off; its counter never loads, so it is never active.
    logic w_unused_music;
    assign w_src          = {squash_snd, home_snd, jump_snd, 1'b0};
    assign w_unused_music = music_snd ^ w_act[0];
`endif

    assign w_edge = w_src ^ r_src_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_act[i] = (r_cnt[i] != 16'd0);
        end
    end

    // Highest-priority active effect, 0 when no effect is active.
    always_comb begin
        w_best = 2'd0;
        if (w_act[3]) begin
            w_best = 2'd3;
        end else if (w_act[2]) begin
            w_best = 2'd2;
        end else if (w_act[1]) begin
            w_best = 2'd1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_best != 2'd0) begin
                    w_state_nx = ST_EFFECT;
                    w_sel_nx   = w_best;
                end
`ifdef SFX_MUSIC_EN
                else if (w_act[0]) begin
                    w_state_nx = ST_MUSIC;
                    w_sel_nx   = 2'd0;
                end
`endif
            end
`ifdef SFX_MUSIC_EN
            ST_MUSIC: begin
                if (w_best != 2'd0) begin
                    w_state_nx = ST_EFFECT;
                    w_sel_nx   = w_best;
                end else if (!w_act[0]) begin
                    w_state_nx = ST_IDLE;
                    w_sel_nx   = 2'd0;
                end
            end
`endif
            ST_EFFECT: begin
                // While the current effect is active, w_best can only be equal
                // or higher, so following w_best gives strict-priority preemption
                // and, once the current one expires, reselection.
                if (w_best != 2'd0) begin
                    w_sel_nx = w_best;
                end
`ifdef SFX_MUSIC_EN
                else if (w_act[0]) begin
                    w_state_nx = ST_MUSIC;
                    w_sel_nx   = 2'd0;
                end
`endif
                else begin
                    w_state_nx = ST_IDLE;
                    w_sel_nx   = 2'd0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_sel_nx   = 2'd0;
            end
        endcase
    end

    // In MUSIC the sel code is 0, which is also the music bit of r_src_q.
    assign w_level = (r_state == ST_IDLE) ? 1'b0 : r_src_q[r_sel];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_src_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_state   <= ST_IDLE;
            r_sel     <= 2'd0;
            r_busy    <= 1'b0;
            r_audio   <= 1'b0;
            r_carrier <= '0;
        end else begin
            r_src_q <= w_src;
            for (int i = 0; i < 4; i++) begin
                if (w_edge[i]) begin
                    r_cnt[i] <= ACT_WIN;
                end else if (r_cnt[i] != 16'd0) begin
                    r_cnt[i] <= r_cnt[i] - 16'd1;
                end
            end
            r_state   <= w_state_nx;
            r_sel     <= w_sel_nx;
            r_busy    <= (w_state_nx == ST_EFFECT);
            r_audio   <= w_level & (r_carrier < volume) & ~mute;
            r_carrier <= r_carrier + PWM_BITS'(1);
        end
    end

    assign audio_out = r_audio;
    assign sel       = r_sel;
    assign sfx_busy  = r_busy;

endmodule

// File: doc/sfx_mixer.md
SFX_MIXER -- requirements
Module: sfx_mixer

Interface
REQ-001 Parameter: ACT_WIN, 16'd40000, clocks a source stays "active" after its last edge (covers tones down to ~315 Hz at 25.175 MHz).
REQ-002 Parameter: PWM_BITS, 3, width of the volume input and of the PWM carrier counter.
REQ-003 Port: clk  input  1  system clock, 25.175 MHz.
REQ-004 Port: reset_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk; this is the only clock and reset.
REQ-005 Port: squash_snd  input  1  square-wave tone from the squash effect generator.
REQ-006 Port: home_snd  input  1  square-wave tone from the frog-home effect generator.
REQ-007 Port: jump_snd  input  1  square-wave tone from the jump effect generator.
REQ-008 Port: music_snd  input  1  background-music square wave.
REQ-009 Port: volume  input  PWM_BITS  output duty in 1/8 steps; 0 is silent.
REQ-010 Port: mute  input  1  forces audio_out low.
REQ-011 Port: audio_out  output  1  PWM-gated audio to the speaker pin, registered.
REQ-012 Port: sel  output  2  selected source: 0 none/music, 1 jump, 2 home, 3 squash.
REQ-013 Port: sfx_busy  output  1  high while an effect (not music) is selected.

Function
REQ-014 All four sources SHALL be registered once (src_q); an edge is src != src_q.
REQ-015 Each source SHALL have a 16-bit activity counter: on an edge, load ACT_WIN; else decrement, saturating at 0; active = counter != 0.
REQ-016 The FSM SHALL have states IDLE, MUSIC, EFFECT.
REQ-017 Priority SHALL be squash > home > jump > music.
REQ-018 IDLE -> EFFECT when any effect is active, else IDLE -> MUSIC when music is active.
REQ-019 MUSIC -> EFFECT when any effect becomes active, selecting the highest-priority active effect.
REQ-020 In EFFECT, a strictly higher-priority active effect SHALL preempt the current one in the next cycle; lower or equal priority SHALL never preempt.
REQ-021 When the selected effect's counter reaches 0, the FSM SHALL reselect: highest remaining active effect (stay EFFECT), else MUSIC if music is active, else IDLE.
REQ-022 Simultaneous activations SHALL resolve by REQ-017.
REQ-023 MUSIC -> IDLE when music's counter reaches 0.
REQ-024 A free-running PWM_BITS carrier counter SHALL wrap 7 -> 0.
REQ-025 audio_out SHALL be registered as level AND (carrier < volume) AND NOT mute, where level is src_q of the selected source; it is 0 in IDLE.
REQ-026 A source transition SHALL appear in the ungated level driving audio_out exactly 2 clocks after it is presented at the input.
REQ-027 sel and sfx_busy SHALL be registered and update in the same cycle as the FSM state.
REQ-028 A volume change SHALL take effect on the next carrier comparison; no latching is applied.

Reset
REQ-029 While reset_n = 0 at a clk edge: state = IDLE, all counters and src_q = 0, carrier = 0, audio_out = 0, sel = 0, sfx_busy = 0.
REQ-030 Reset mid-effect SHALL abandon the effect; after release, a still-toggling source re-activates on its next edge.

Configuration
REQ-031 With macro SFX_MUSIC_EN defined, the music channel is present as specified.
REQ-032 Without SFX_MUSIC_EN, music_snd is ignored and the MUSIC state is removed: EFFECT falls back to IDLE, and IDLE enters only EFFECT.

Verification
REQ-033 Jump only: jump_snd toggles every 14261 clocks, volume = 7 -> sel = 1, sfx_busy = 1, audio_out high 7 of 8 carrier cycles while jump is high; idle ACT_WIN+2 clocks after the last edge -> sel = 0.
REQ-034 Preempt: jump active, then squash toggles -> sel goes 1 -> 3 one cycle after squash is seen active; squash stops -> sel returns to 1 after 40000 clocks.
REQ-035 No preempt: squash active, then jump toggles -> sel stays 3.
REQ-036 Music fallback (SFX_MUSIC_EN defined): music running, home toggles -> sel 0 -> 2, sfx_busy = 1; home stops -> MUSIC, sfx_busy = 0, audio_out follows music.
REQ-037 volume = 0 or mute = 1 during an effect -> audio_out = 0 with sel unchanged.
REQ-038 reset_n pulsed low for 1 clk during squash -> next cycle all outputs 0 and state IDLE; squash re-selected after its next edge.
